// File: rtl/flappy_pkg.sv
// Shared constants, LFSR helper and scroller state encoding for the flappy pipeline.
package flappy_pkg;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int PIPE_W   = 60;
  localparam int GAP_H    = 120;
  localparam int GAP_MIN  = 40;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Right-shift Galois mask for x^8+x^6+x^5+x^4+1
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b001,
    ST_RUN    = 3'b010,
    ST_FROZEN = 3'b100
  } scr_state_t;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {1'b0, v[7:1]} ^ (v[0] ? LFSR_TAPS : 8'h00);
  endfunction
endpackage

// File: rtl/score_bcd3.sv
// Three-digit BCD score counter: saturates at 999, pulses on every accepted increment.
module score_bcd3 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        inc,
  output logic [11:0] score,
  output logic        pulse
);
  logic [3:0] d0, d1, d2;
  logic       sat;

  assign sat   = (d2 == 4'd9) && (d1 == 4'd9) && (d0 == 4'd9);
  assign score = {d2, d1, d0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d0    <= 4'd0;
      d1    <= 4'd0;
      d2    <= 4'd0;
      pulse <= 1'b0;
    end else if (clr) begin
      d0    <= 4'd0;
      d1    <= 4'd0;
      d2    <= 4'd0;
      pulse <= 1'b0;
    end else begin
      // pulse still fires at 999 so downstream sees every cleared pipe
      pulse <= inc;
      if (inc && !sat) begin
        if (d0 != 4'd9) d0 <= d0 + 4'd1;
        else begin
          d0 <= 4'd0;
          if (d1 != 4'd9) d1 <= d1 + 4'd1;
          else begin
            d1 <= 4'd0;
            d2 <= d2 + 4'd1;
          end
        end
      end
    end
  end
endmodule

// File: rtl/pipe_scroller.sv
// Single-pipe scroller with LFSR gap placement and BCD scoring.
// Optional PIPE_SPEEDUP_EN: step grows 1..4 px with pipes cleared.
module pipe_scroller
  import flappy_pkg::*;
#(
  parameter int SCREEN_W = flappy_pkg::SCREEN_W,
  parameter int PIPE_W   = flappy_pkg::PIPE_W,
  parameter int GAP_H    = flappy_pkg::GAP_H,
  parameter int GAP_MIN  = flappy_pkg::GAP_MIN,
  parameter int MOVE_DIV = 250000
) (
  input  logic        Clk,
  input  logic        reset_n,
  input  logic        Start,
  input  logic        Lose,
  input  logic        Ack,
  input  logic [9:0]  Bird_X,
  output logic [9:0]  X_Edge_Left,
  output logic [9:0]  X_Edge_Right,
  output logic [9:0]  Y_Edge_Top,
  output logic [9:0]  Y_Edge_Bottom,
  output logic [11:0] Score,
  output logic        Pipe_Passed,
  output logic        Running
);
  localparam int              DIV_W     = $clog2(MOVE_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(MOVE_DIV - 1);
  localparam logic [9:0]      RESPAWN_X = 10'(SCREEN_W + PIPE_W);
  localparam logic [9:0]      GAP_BASE  = 10'(GAP_MIN);

  scr_state_t       state, state_nx;
  logic [DIV_W-1:0] div;
  logic             passed;
  logic [7:0]       lfsr;
  logic [9:0]       step_px, gap_new;
  logic             tick, score_ev, clr;

  assign gap_new  = GAP_BASE + {2'b00, lfsr};
  assign tick     = (state == ST_RUN) && (div == DIV_LAST);
  assign score_ev = (state == ST_RUN) && !Lose && !passed && (X_Edge_Right < Bird_X);
  assign clr      = (state == ST_IDLE) && Start;
  assign Running  = (state == ST_RUN);

  assign X_Edge_Left   = (X_Edge_Right >= 10'(PIPE_W)) ? X_Edge_Right - 10'(PIPE_W) : 10'd0;
  assign Y_Edge_Bottom = Y_Edge_Top + 10'(GAP_H);

`ifdef PIPE_SPEEDUP_EN
  logic [4:0] cleared;
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n)                         cleared <= 5'd0;
    else if (clr)                         cleared <= 5'd0;
    else if (score_ev && cleared != 5'd31) cleared <= cleared + 5'd1;
  end
  // cleared/8 on a 5-bit counter tops out at 3, so the step caps at 4 px
  assign step_px = 10'd1 + {8'd0, cleared[4:3]};
`else
  assign step_px = 10'd1;
`endif

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) lfsr <= LFSR_SEED;
    else          lfsr <= lfsr_next(lfsr);
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = ST_IDLE;
    case (state)
      ST_IDLE:   state_nx = Start ? ST_RUN : ST_IDLE;
      ST_RUN:    state_nx = Lose ? ST_FROZEN : ST_RUN;
      ST_FROZEN: state_nx = Ack ? ST_IDLE : ST_FROZEN;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      X_Edge_Right <= RESPAWN_X;
      Y_Edge_Top   <= GAP_BASE + {2'b00, LFSR_SEED};
      div          <= '0;
      passed       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          X_Edge_Right <= RESPAWN_X;
          if (Start) begin
            div        <= '0;
            passed     <= 1'b0;
            Y_Edge_Top <= gap_new;
          end
        end
        // Lose freezes everything on its own cycle, including a coincident step
        ST_RUN: if (!Lose) begin
          div <= tick ? '0 : div + DIV_W'(1);
          if (score_ev) passed <= 1'b1;
          if (tick) begin
            if (X_Edge_Right > step_px) X_Edge_Right <= X_Edge_Right - step_px;
            else begin
              X_Edge_Right <= RESPAWN_X;
              passed       <= 1'b0;
              Y_Edge_Top   <= gap_new;
            end
          end
        end
        ST_FROZEN: if (Ack) X_Edge_Right <= RESPAWN_X;
        default:   X_Edge_Right <= RESPAWN_X;
      endcase
    end
  end

  score_bcd3 u_score (
    .clk   (Clk),
    .rst_n (reset_n),
    .clr   (clr),
    .inc   (score_ev),
    .score (Score),
    .pulse (Pipe_Passed)
  );
endmodule
